// File: rtl/c64_dma_pkg.sv
// Shared state encodings, C64 R/W polarity and the latched request type
// for the C64-side DMA responder.
package c64_dma_pkg;

   localparam logic [2:0] ST_IDLE   = 3'd0;
   localparam logic [2:0] ST_ARM    = 3'd1;
   localparam logic [2:0] ST_ACCESS = 3'd2;
   localparam logic [2:0] ST_HOLD   = 3'd3;
   localparam logic [2:0] ST_GAP    = 3'd4;

   // Levels of the C64 R/W pin; the request side uses the opposite sense.
   localparam logic RW_READ  = 1'b1;
   localparam logic RW_WRITE = 1'b0;

   typedef struct packed {
      logic       write;
      logic [7:0] data;
   } dma_op_t;

   function automatic logic rw_level(input logic is_write);
      return is_write ? RW_WRITE : RW_READ;
   endfunction

endpackage

// File: rtl/c64_dma_responder_phi2_sync.sv
// Multi-flop synchronizer with single-cycle rise/fall pulses, used for the
// asynchronous C64 PHI2 and BA pins.
module phi2_sync
   import c64_dma_pkg::*;
#(
   parameter int STAGES = 2
) (
   input  logic clk,
   input  logic reset,
   input  logic async_in,
   output logic sync_out,
   output logic rise,
   output logic fall
);

   logic [STAGES-1:0] chain;
   logic              prev;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         chain <= '0;
         prev  <= 1'b0;
      end else begin
         chain <= {chain[STAGES-2:0], async_in};
         prev  <= chain[STAGES-1];
      end
   end

   assign sync_out = chain[STAGES-1];
   assign rise     = chain[STAGES-1] & ~prev;
   assign fall     = ~chain[STAGES-1] & prev;

endmodule

// File: rtl/c64_dma_responder.sv
// Responder side of the REU toggle handshake: turns each pending request into
// exactly one C64 expansion-port bus cycle under /DMA, then toggles dma_ack.
module c64_dma_responder
   import c64_dma_pkg::*;
#(
   parameter int SAMPLE_DELAY = 6,
   parameter int SYNC_STAGES  = 2
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [15:0] dma_a,
   input  logic [7:0]  dma_d,
   input  logic        dma_rw,
   input  logic        dma_req,
   output logic [7:0]  dma_q,
   output logic        dma_ack,
   input  logic        phi2,
   input  logic        ba,
   output logic        dma_n,
   output logic [15:0] bus_a_out,
   output logic        bus_a_oe,
   output logic        bus_rw_out,
   output logic        bus_rw_oe,
   output logic [7:0]  bus_d_out,
   output logic        bus_d_oe,
   input  logic [7:0]  bus_d_in
);

   localparam logic [3:0] SAMPLE_AT = 4'(SAMPLE_DELAY);

   logic       phi2_s;
   logic       rise;
   logic       fall;
   logic       ba_s;
   logic       ba_rise_unused;
   logic       ba_fall_unused;
   logic [2:0] state;
   logic [3:0] cnt;
   dma_op_t    op;
   logic       pending;
   logic       start_access;

   phi2_sync #(.STAGES(SYNC_STAGES)) u_phi2_sync (
      .clk      (clk),
      .reset    (reset),
      .async_in (phi2),
      .sync_out (phi2_s),
      .rise     (rise),
      .fall     (fall)
   );

   phi2_sync #(.STAGES(SYNC_STAGES)) u_ba_sync (
      .clk      (clk),
      .reset    (reset),
      .async_in (ba),
      .sync_out (ba_s),
      .rise     (ba_rise_unused),
      .fall     (ba_fall_unused)
   );

   assign pending = dma_req ^ dma_ack;

   // A GAP rise with the bus free chains straight into the next access.
   assign start_access = rise & ba_s &
                         ((state == ST_ARM) | ((state == ST_GAP) & pending));

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state      <= ST_IDLE;
         cnt        <= 4'd0;
         op         <= '0;
         dma_q      <= 8'h00;
         dma_ack    <= 1'b0;
         dma_n      <= 1'b1;
         bus_a_out  <= 16'h0000;
         bus_a_oe   <= 1'b0;
         bus_rw_out <= RW_READ;
         bus_rw_oe  <= 1'b0;
         bus_d_out  <= 8'h00;
         bus_d_oe   <= 1'b0;
      end else if (start_access) begin
         state      <= ST_ACCESS;
         cnt        <= 4'd0;
         op.write   <= dma_rw;
         op.data    <= dma_d;
         bus_a_out  <= dma_a;
         bus_a_oe   <= 1'b1;
         bus_rw_out <= rw_level(dma_rw);
         bus_rw_oe  <= 1'b1;
         bus_d_oe   <= 1'b0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (pending) begin
                  dma_n <= 1'b0;
                  state <= ST_ARM;
               end
            end
            ST_ARM: begin
            end
            ST_ACCESS: begin
               cnt <= cnt + 4'd1;
               // PHI2 ending early still completes the access; writes then never drive data.
               if (fall) begin
                  if (!op.write) begin
                     dma_q <= bus_d_in;
                  end
                  bus_a_oe  <= 1'b0;
                  bus_rw_oe <= 1'b0;
                  bus_d_oe  <= 1'b0;
                  dma_ack   <= ~dma_ack;
                  state     <= ST_GAP;
               end else if (cnt == SAMPLE_AT) begin
                  if (op.write) begin
                     bus_d_out <= op.data;
                     bus_d_oe  <= 1'b1;
                  end else begin
                     dma_q <= bus_d_in;
                  end
                  state <= ST_HOLD;
               end
            end
            ST_HOLD: begin
               if (fall) begin
                  bus_a_oe  <= 1'b0;
                  bus_rw_oe <= 1'b0;
                  bus_d_oe  <= 1'b0;
                  dma_ack   <= ~dma_ack;
                  state     <= ST_GAP;
               end
            end
            ST_GAP: begin
               if (rise) begin
                  if (pending) begin
                     state <= ST_ARM;
                  end else begin
                     dma_n <= 1'b1;
                     state <= ST_IDLE;
                  end
               end
            end
            default: begin
               state <= ST_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_c64_dma_responder.sv
// Scoreboard bench for c64_dma_responder: a C64 bus model with memory, directed
// requests pushing expectations, and a monitor that checks every dma_ack toggle.
module tb_c64_dma_responder;

   localparam int SYNC = 2;

   logic        clk = 1'b0;
   logic        reset;
   logic [15:0] dma_a;
   logic [7:0]  dma_d;
   logic        dma_rw;
   logic        dma_req;
   logic [7:0]  dma_q;
   logic        dma_ack;
   logic        phi2;
   logic        ba;
   logic        dma_n;
   logic [15:0] bus_a_out;
   logic        bus_a_oe;
   logic        bus_rw_out;
   logic        bus_rw_oe;
   logic [7:0]  bus_d_out;
   logic        bus_d_oe;
   logic [7:0]  bus_d_in;

   typedef struct {
      string       name;
      logic        write;
      logic [15:0] addr;
      logic [7:0]  data;
      logic        d_oe;
   } exp_t;

   exp_t       sb[$];
   int         checks = 0;
   int         failures = 0;
   int         phi_high = 20;
   int         phi_low = 20;
   int         rise_total = 0;
   logic [7:0] mem [0:65535];
   logic       last_ack;
   logic [15:0] seen_addr;
   logic       seen_rw;
   logic       seen_d_oe;

   c64_dma_responder #(.SAMPLE_DELAY(6), .SYNC_STAGES(SYNC)) dut (
      .clk        (clk),
      .reset      (reset),
      .dma_a      (dma_a),
      .dma_d      (dma_d),
      .dma_rw     (dma_rw),
      .dma_req    (dma_req),
      .dma_q      (dma_q),
      .dma_ack    (dma_ack),
      .phi2       (phi2),
      .ba         (ba),
      .dma_n      (dma_n),
      .bus_a_out  (bus_a_out),
      .bus_a_oe   (bus_a_oe),
      .bus_rw_out (bus_rw_out),
      .bus_rw_oe  (bus_rw_oe),
      .bus_d_out  (bus_d_out),
      .bus_d_oe   (bus_d_oe),
      .bus_d_in   (bus_d_in)
   );

   always #5 clk = ~clk;

   // PHI2 is free-running and deliberately offset from the system clock.
   initial begin
      phi2 = 1'b0;
      #3;
      forever begin
         phi2 = 1'b1;
         #(phi_high * 10);
         phi2 = 1'b0;
         #(phi_low * 10);
      end
   end

   always @(posedge phi2) rise_total++;

   // Bus model: memory preload and write capture at the end of PHI2 high.
   initial begin
      for (int i = 0; i < 65536; i++) mem[i] = 8'h00;
      mem[16'hD020] = 8'h0E;
      mem[16'h1000] = 8'hA0;
      mem[16'h1001] = 8'hA1;
      mem[16'h1002] = 8'hA2;
      mem[16'h1003] = 8'hA3;
      mem[16'h0800] = 8'h5A;
      forever begin
         @(negedge phi2);
         if (bus_a_oe && bus_rw_oe && bus_d_oe && !bus_rw_out) mem[bus_a_out] = bus_d_out;
      end
   end

   assign bus_d_in = bus_a_oe ? mem[bus_a_out] : 8'hFF;

   task automatic checkOutput(input string name, input logic [31:0] actual,
                              input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         failures++;
         $display("[TB] FAIL %s actual=%0h expected=%0h", name, actual, expected);
      end
   endtask

   task automatic applyStimulus(input string name, input logic rw, input logic [15:0] a,
                                input logic [7:0] d, input logic [7:0] exp_data,
                                input logic exp_d_oe);
      exp_t e;
      @(negedge clk);
      e.name  = name;
      e.write = rw;
      e.addr  = a;
      e.data  = exp_data;
      e.d_oe  = exp_d_oe;
      sb.push_back(e);
      dma_a   = a;
      dma_d   = d;
      dma_rw  = rw;
      dma_req = ~dma_req;
   endtask

   task automatic waitAck(input string name, output int n_high, output int n_rise);
      int n;
      int r0;
      n      = 0;
      n_high = 0;
      r0     = rise_total;
      while (dma_ack !== dma_req && n < 200) begin
         @(negedge clk);
         n++;
         if (dma_n) n_high++;
      end
      n_rise = rise_total - r0;
      if (dma_ack !== dma_req) checkOutput({name, "_ack_timeout"}, 32'(dma_ack), 32'(dma_req));
   endtask

   // Monitor: every ack toggle retires the oldest expectation.
   always @(negedge clk) begin
      exp_t e;
      if (reset) begin
         last_ack  = 1'b0;
         seen_d_oe = 1'b0;
         sb.delete();
      end else begin
         if (bus_a_oe) begin
            seen_addr = bus_a_out;
            seen_rw   = bus_rw_out;
         end
         if (bus_d_oe) seen_d_oe = 1'b1;
         if (dma_ack !== last_ack) begin
            last_ack = dma_ack;
            if (sb.size() == 0) begin
               checkOutput("spurious_ack", 32'(dma_ack), 32'(dma_req));
            end else begin
               e = sb.pop_front();
               checkOutput({e.name, "_addr"}, 32'(seen_addr), 32'(e.addr));
               checkOutput({e.name, "_rw"}, 32'(seen_rw), 32'(!e.write));
               checkOutput({e.name, "_d_oe"}, 32'(seen_d_oe), 32'(e.d_oe));
               if (e.write) checkOutput({e.name, "_mem"}, 32'(mem[e.addr]), 32'(e.data));
               else         checkOutput({e.name, "_q"}, 32'(dma_q), 32'(e.data));
            end
            seen_d_oe = 1'b0;
         end
      end
   end

   initial begin
      #1_000_000;
      $display("[TB] FAIL watchdog expired");
      $fatal(1, "[TB] watchdog");
   end

   initial begin
      int         nh;
      int         nr;
      int         sum_high;
      int         sum_rise;
      int         oe_count;
      int         r0;
      int         n;
      logic [7:0] burst_exp [4];

      burst_exp = '{8'hA0, 8'hA1, 8'hA2, 8'hA3};
      reset   = 1'b1;
      dma_req = 1'b0;
      dma_a   = 16'h0000;
      dma_d   = 8'h00;
      dma_rw  = 1'b0;
      ba      = 1'b1;
      repeat (4) @(negedge clk);
      checkOutput("rst_dma_n", 32'(dma_n), 32'h1);
      checkOutput("rst_ack", 32'(dma_ack), 32'h0);
      checkOutput("rst_q", 32'(dma_q), 32'h00);
      checkOutput("rst_a_out", 32'(bus_a_out), 32'h0000);
      checkOutput("rst_d_out", 32'(bus_d_out), 32'h00);
      checkOutput("rst_rw_out", 32'(bus_rw_out), 32'h1);
      checkOutput("rst_oes", 32'({bus_a_oe, bus_rw_oe, bus_d_oe}), 32'h0);
      reset = 1'b0;
      repeat (3) @(negedge clk);

      $display("[TB] single read");
      applyStimulus("rd_d020", 1'b0, 16'hD020, 8'h00, 8'h0E, 1'b0);
      @(negedge clk);
      checkOutput("dma_n_low_1clk", 32'(dma_n), 32'h0);
      waitAck("rd_d020", nh, nr);
      @(posedge phi2);
      repeat (SYNC + 3) @(negedge clk);
      checkOutput("dma_n_release", 32'(dma_n), 32'h1);

      $display("[TB] single write");
      applyStimulus("wr_0400", 1'b1, 16'h0400, 8'h41, 8'h41, 1'b1);
      waitAck("wr_0400", nh, nr);

      $display("[TB] burst of four reads");
      sum_high = 0;
      sum_rise = 0;
      for (int i = 0; i < 4; i++) begin
         applyStimulus($sformatf("burst%0d", i), 1'b0, 16'h1000 + 16'(i), 8'h00,
                       burst_exp[i], 1'b0);
         waitAck($sformatf("burst%0d", i), nh, nr);
         if (i > 0) begin
            sum_high += nh;
            sum_rise += nr;
         end
      end
      checkOutput("burst_dma_n_low", 32'(sum_high), 32'd0);
      checkOutput("burst_phi2_cycles", 32'(sum_rise), 32'd3);

      $display("[TB] ba held low");
      @(negedge phi2);
      ba = 1'b0;
      applyStimulus("rd_ba", 1'b0, 16'h0800, 8'h00, 8'h5A, 1'b0);
      oe_count = 0;
      r0 = rise_total;
      n = 0;
      while ((rise_total - r0) < 3 && n < 2000) begin
         @(negedge clk);
         n++;
         if (bus_a_oe || bus_rw_oe || bus_d_oe) oe_count++;
      end
      checkOutput("ba_low_no_oe", 32'(oe_count), 32'd0);
      checkOutput("ba_low_pending", 32'(dma_ack ^ dma_req), 32'h1);
      @(negedge phi2);
      ba = 1'b1;
      waitAck("rd_ba", nh, nr);
      checkOutput("ba_first_rise", 32'(nr), 32'd1);

      $display("[TB] reset during write hold");
      applyStimulus("wr_0500", 1'b1, 16'h0500, 8'h55, 8'h00, 1'b1);
      n = 0;
      while (bus_d_oe !== 1'b1 && n < 200) begin
         @(negedge clk);
         n++;
      end
      checkOutput("hold_reached", 32'(bus_d_oe), 32'h1);
      #2;
      reset = 1'b1;
      #1;
      checkOutput("rst_mid_dma_n", 32'(dma_n), 32'h1);
      checkOutput("rst_mid_oes", 32'({bus_a_oe, bus_rw_oe, bus_d_oe}), 32'h0);
      checkOutput("rst_mid_ack", 32'(dma_ack), 32'h0);
      dma_req = dma_ack;
      repeat (3) @(negedge clk);
      reset = 1'b0;
      repeat (2) @(posedge phi2);
      repeat (SYNC + 3) @(negedge clk);
      checkOutput("rst_no_late_ack", 32'(dma_ack), 32'h0);
      checkOutput("rst_no_write", 32'(mem[16'h0500]), 32'h00);

      $display("[TB] sample delay past short phi2 high");
      phi_high = 5;
      repeat (2) @(posedge phi2);
      applyStimulus("wr_long", 1'b1, 16'h0600, 8'h77, 8'h00, 1'b0);
      waitAck("wr_long", nh, nr);
      repeat (2) @(posedge phi2);
      repeat (SYNC + 3) @(negedge clk);
      checkOutput("long_single_ack", 32'(dma_ack), 32'(dma_req));
      checkOutput("long_sb_empty", 32'(sb.size()), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/c64_dma_responder.md
# c64_dma_responder

Responder end of the C64-side DMA toggle handshake (`dma_a`/`dma_d`/`dma_rw`/`dma_req` → `dma_q`/`dma_ack`) used by the REU DMA engine. It takes each pending request and performs exactly one C64 expansion-port bus cycle: it asserts /DMA, aligns to PHI2, drives address, R/W and write data, and captures read data. It then completes the handshake by toggling `dma_ack`. It sits between the DMA engine and the cartridge-port I/O buffers.

## Interface

Parameters:
- `SAMPLE_DELAY`, default 6: clk cycles after a detected PHI2 rise at which read data is sampled and write data is first driven. Range 1..15.
- `SYNC_STAGES`, default 2: synchronizer depth for `phi2` and `ba`. Range 2..3.

Ports:
- `clk` in 1: system clock; the block uses one clock only.
- `reset` in 1: asynchronous, active-high reset.
- `dma_a` in 16: request address; valid while a request is pending.
- `dma_d` in 8: write data.
- `dma_rw` in 1: 1 = write to C64, 0 = read from C64.
- `dma_req` in 1: toggle; a request is pending when `dma_req != dma_ack`.
- `dma_q` out 8: read data; valid from the `dma_ack` toggle until the next read completes.
- `dma_ack` out 1: toggle; flips once per completed access.
- `phi2` in 1: C64 PHI2, asynchronous.
- `ba` in 1: C64 BA, asynchronous.
- `dma_n` out 1: /DMA to the port, active low.
- `bus_a_out` out 16: address to drive.
- `bus_a_oe` out 1: address buffer enable.
- `bus_rw_out` out 1: C64 R/W level (1 = read, 0 = write).
- `bus_rw_oe` out 1: R/W buffer enable.
- `bus_d_out` out 8: data to drive.
- `bus_d_oe` out 1: data buffer enable.
- `bus_d_in` in 8: data from the port.

## Operation

Input conditioning:
- `phi2` and `ba` each pass through a `SYNC_STAGES`-flop synchronizer, giving `phi2_s` and `ba_s`.
- `rise` and `fall` are single-cycle edge pulses derived from `phi2_s`.

States, held in a 3-bit register:
- IDLE:
  - `dma_n`=1, all OEs 0.
  - If a request is pending, set `dma_n`←0 and go to ARM.
- ARM:
  - On `rise` with `ba_s`=1, go to ACCESS and load the delay counter with 0.
  - On `rise` with `ba_s`=0, stay in ARM; the bus is still owned by the VIC or CPU.
- ACCESS:
  - Address and R/W are driven on entry: `bus_a_out`←`dma_a`, `bus_rw_out`←~`dma_rw`, `bus_a_oe`=`bus_rw_oe`=1.
  - The counter increments every cycle.
  - When the counter equals `SAMPLE_DELAY`:
    - Read: `dma_q`←`bus_d_in`.
    - Write: `bus_d_out`←`dma_d`, `bus_d_oe`←1.
  - Go to HOLD.
- HOLD:
  - Outputs are held.
  - On `fall`: drop all OEs, toggle `dma_ack`, go to GAP.
- GAP:
  - `dma_n` stays 0.
  - On `rise`, if a request is pending and `ba_s`=1, go straight to ACCESS with the same actions as ARM; back-to-back bursts therefore cost no extra PHI2 cycle.
  - On `rise`, if a request is pending and `ba_s`=0, go to ARM.
  - On `rise`, if no request is pending, set `dma_n`←1 and go to IDLE.

Rules:
- Request inputs are sampled only on ACCESS entry; changes after that are ignored until the next access.
- A `fall` while in ACCESS (because `SAMPLE_DELAY` is too long) still completes the access:
  - The read sample is taken on that same cycle.
  - For a write, `bus_d_oe` is never asserted and the access is acked anyway.
- Only one access is performed per PHI2 high phase.

## Timing

Reset values: `dma_n`=1; `dma_ack`=0; `dma_q`=8'h00; `bus_a_out`=0; `bus_d_out`=0; `bus_rw_out`=1; all OEs 0; state IDLE; synchronizers cleared to 0.

Reset mid-access:
- All OEs drop and `dma_n` returns to 1 immediately (asynchronous).
- No ack is issued.
- The initiator resynchronizes by copying `dma_ack` into its `dma_req`.

Latency:
- From pending to `dma_n` low: 1 clk.
- From `rise` to driven address/R/W: 1 clk.
- From `fall` to `dma_ack` toggle: 1 clk.
- All edges are seen `SYNC_STAGES` clks after the pin.

Handshake:
- At most one outstanding request.
- Exactly one `dma_ack` toggle per access.
- `dma_ack` never toggles while no request is pending.

## Structure

- `c64_dma_pkg`: state enum (IDLE, ARM, ACCESS, HOLD, GAP) and the R/W polarity constants.
- Sub-module `phi2_sync`: synchronizer plus rise/fall detector for `phi2`, also used for `ba`; no edge outputs are needed for `ba`.
- The FSM, 4-bit delay counter and bus output registers live in the top module.

## Test plan

- Single read: `dma_a`=16'hD020, `dma_rw`=0, bus model returns 8'h0E. Required: `dma_n` low, one PHI2 cycle with address 16'hD020, `dma_q`=8'h0E, `dma_ack` flips, `dma_n` returns high at the next `rise`.
- Write: `dma_a`=16'h0400, `dma_d`=8'h41, `dma_rw`=1. Required: `bus_rw_out`=0, `bus_d_oe` high from `SAMPLE_DELAY` until `fall`, bus model memory[16'h0400]=8'h41.
- Burst of 4 reads issued immediately after each ack. Required: 4 consecutive PHI2 cycles, `dma_n` continuously low, 4 ack toggles.
- `ba` held low for 3 PHI2 cycles after a request. Required: no OEs asserted during those cycles; the access occurs on the first `rise` with `ba` high.
- `reset` pulsed during HOLD of a write. Required: OEs and `dma_n` released the same cycle; `dma_ack`=0; no later spurious ack.
- `SAMPLE_DELAY` longer than the PHI2 high phase on a write. Required: `bus_d_oe` never asserted; `dma_ack` still toggles once.
